// File: rtl/observer_pkg.sv
// Shared constants and helpers for the multi-channel change observer.
// OBSERVER_DEBOUNCE_EN enables the per-channel stability filter.
package observer_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  localparam int MAX_CH    = 32;

`ifdef OBSERVER_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [5:0] popcnt(input logic [MAX_CH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_CH; i++)
      c = c + {5'd0, v[i]};
    return c;
  endfunction

  function automatic logic [4:0] lowest(input logic [MAX_CH-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--)
      if (v[i]) r = 5'(i);
    return r;
  endfunction

endpackage

// File: rtl/multi_change_observer_detect.sv
// One observed line: synchroniser, optional debounce filter, prev
// register and raw edge. Filter present when OBSERVER_DEBOUNCE_EN is set.
module change_detect_ch
  import observer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int DEB_CYCLES  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_edge
);

  logic w_s;
  logic w_f;
  logic r_prev;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = i_d;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_d;
        for (int i = 1; i < SYNC_STAGES; i++)
          r_sync[i] <= r_sync[i-1];
      end
    end
    assign w_s = r_sync[SYNC_STAGES-1];
  end

  if (DEB_CYCLES > 0) begin : g_deb
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic          r_filt;
    logic [DW-1:0] r_dcnt;
    // filter follows s only after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_filt <= 1'b0;
        r_dcnt <= '0;
      end else if (w_s == r_filt) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
        r_filt <= w_s;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
    assign w_f = r_filt;
  end else begin : g_nodeb
    assign w_f = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_f;
  end

  always_comb begin
    unique case (EDGE_MODE)
      EDGE_FALL: o_edge = ~w_f & r_prev;
      EDGE_BOTH: o_edge = w_f ^ r_prev;
      default:   o_edge = w_f & ~r_prev;
    endcase
  end

endmodule

// File: rtl/multi_change_observer.sv
// Multi-channel edge observer: arming, masking, sticky pending, first
// event capture, saturating counter. OBSERVER_DEBOUNCE_EN adds filtering.
module multi_change_observer
  import observer_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int CNT_W       = 8,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_in,
  input  logic [N_CH-1:0]        ch_mask,
  output logic                   pulse,
  output logic [N_CH-1:0]        edge_vec,
  output logic [N_CH-1:0]        pending,
  input  logic                   clr_valid,
  input  logic [N_CH-1:0]        clr_mask,
  output logic                   first_valid,
  output logic [idx_w(N_CH)-1:0] first_ch,
  output logic [CNT_W-1:0]       evt_count,
  input  logic                   cnt_clr
);

  localparam int IW      = idx_w(N_CH);
  localparam int DEB_LAT = DEB_EN ? DEB_CYCLES : 0;
  localparam int ARM_N   = SYNC_STAGES + DEB_LAT + 1;
  localparam int AW      = $clog2(ARM_N + 1);
  localparam int SW      = CNT_W + 7;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  logic [AW-1:0]     r_arm;
  logic              w_armed;
  logic [N_CH-1:0]   w_raw;
  logic [N_CH-1:0]   w_edge;
  logic [N_CH-1:0]   w_clr;
  logic [N_CH-1:0]   w_pend_nxt;
  logic [MAX_CH-1:0] w_edge32;
  logic [5:0]        w_pop;
  logic [SW-1:0]     w_sum;
  logic [CNT_W-1:0]  w_cnt_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    change_detect_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE),
      .DEB_CYCLES  (DEB_LAT)
    ) u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (ch_in[g]),
      .o_edge (w_raw[g])
    );
  end

  // edges are ignored until the synchroniser and prev regs hold real data
  assign w_armed = (r_arm == AW'(ARM_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_arm <= '0;
    else if (!w_armed) r_arm <= r_arm + AW'(1);
  end

  assign w_edge     = w_raw & ch_mask & {N_CH{w_armed}};
  assign w_clr      = clr_valid ? clr_mask : '0;
  assign w_pend_nxt = (pending & ~w_clr) | w_edge;

  always_comb begin
    w_edge32 = '0;
    w_edge32[N_CH-1:0] = w_edge;
  end

  assign w_pop     = popcnt(w_edge32);
  assign w_sum     = (cnt_clr ? '0 : SW'(evt_count)) + SW'(w_pop);
  assign w_cnt_nxt = (w_sum > CMAX) ? CMAX[CNT_W-1:0] : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse       <= 1'b0;
      edge_vec    <= '0;
      pending     <= '0;
      first_valid <= 1'b0;
      first_ch    <= '0;
      evt_count   <= '0;
    end else begin
      pulse     <= |w_edge;
      edge_vec  <= w_edge;
      pending   <= w_pend_nxt;
      evt_count <= w_cnt_nxt;
      if (!first_valid || pending == '0) begin
        if (|w_edge) begin
          first_valid <= 1'b1;
          first_ch    <= IW'(lowest(w_edge32));
        end else begin
          first_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_change_observer.sv
// Bench for multi_change_observer: cycle model on the default instance
// plus directed checks on counter-width and both-edge instances.
module tb_multi_change_observer;

`ifdef OBSERVER_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int SYNC = 2;
  localparam int ARM  = SYNC + DEB + 1;
  localparam int LAT  = SYNC + DEB + 1;

  logic clk;
  logic rst_n;

  logic [2:0] a_in, a_mask, a_clrm, a_edge, a_pend;
  logic       a_clrv, a_cc, a_pulse, a_fv;
  logic [1:0] a_fch;
  logic [7:0] a_cnt;

  logic [2:0] b_in, b_mask, b_clrm, b_edge, b_pend;
  logic       b_clrv, b_cc, b_pulse, b_fv;
  logic [1:0] b_fch;
  logic [1:0] b_cnt;

  logic [2:0] c_in, c_mask, c_clrm, c_edge, c_pend;
  logic       c_clrv, c_cc, c_pulse, c_fv;
  logic [1:0] c_fch;
  logic [7:0] c_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  multi_change_observer #(.DEB_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_in(a_in), .ch_mask(a_mask),
    .pulse(a_pulse), .edge_vec(a_edge), .pending(a_pend),
    .clr_valid(a_clrv), .clr_mask(a_clrm), .first_valid(a_fv),
    .first_ch(a_fch), .evt_count(a_cnt), .cnt_clr(a_cc)
  );

  multi_change_observer #(.CNT_W(2), .DEB_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_in(b_in), .ch_mask(b_mask),
    .pulse(b_pulse), .edge_vec(b_edge), .pending(b_pend),
    .clr_valid(b_clrv), .clr_mask(b_clrm), .first_valid(b_fv),
    .first_ch(b_fch), .evt_count(b_cnt), .cnt_clr(b_cc)
  );

  multi_change_observer #(.EDGE_MODE(2), .DEB_CYCLES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .ch_in(c_in), .ch_mask(c_mask),
    .pulse(c_pulse), .edge_vec(c_edge), .pending(c_pend),
    .clr_valid(c_clrv), .clr_mask(c_clrm), .first_valid(c_fv),
    .first_ch(c_fch), .evt_count(c_cnt), .cnt_clr(c_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model of instance A: the synced view of ch_in is simply the input
  // sampled SYNC clocks earlier, kept in a history queue.
  logic [2:0] hist[$];
  int         m_t;
  logic [2:0] m_edge, m_pend;
  logic       m_pulse, m_fv;
  logic [1:0] m_fch;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] e;
    int pc;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_front(3'b000);
      m_t = 0; m_edge = 0; m_pend = 0; m_pulse = 0;
      m_fv = 0; m_fch = 0; m_cnt = 0;
    end else begin
      m_t++;
      hist.push_front(a_in);
      void'(hist.pop_back());
      e = (m_t >= ARM + 1) ? (hist[SYNC] & ~hist[SYNC+1] & a_mask) : 3'b000;
      pc = 0;
      for (int i = 0; i < 3; i++) pc += e[i];
      if (!m_fv || m_pend == 0) begin
        if (e != 0) begin
          m_fv = 1;
          for (int i = 2; i >= 0; i--) if (e[i]) m_fch = 2'(i);
        end else begin
          m_fv = 0;
        end
      end
      m_pend  = (m_pend & ~(a_clrv ? a_clrm : 3'b000)) | e;
      m_cnt   = (a_cc ? 0 : m_cnt) + pc;
      if (m_cnt > 255) m_cnt = 255;
      m_edge  = e;
      m_pulse = (e != 0);
    end
  end

`ifndef OBSERVER_DEBOUNCE_EN
  always @(negedge clk) begin
    chk("m_edge",  32'(a_edge),  32'(m_edge));
    chk("m_pulse", 32'(a_pulse), 32'(m_pulse));
    chk("m_pend",  32'(a_pend),  32'(m_pend));
    chk("m_fv",    32'(a_fv),    32'(m_fv));
    if (m_fv) chk("m_fch", 32'(a_fch), 32'(m_fch));
    chk("m_cnt",   32'(a_cnt),   32'(m_cnt));
  end
`endif

  initial begin
    rst_n = 1'b0;
    a_in = 3'b111; a_mask = 3'b111; a_clrv = 0; a_clrm = 0; a_cc = 0;
    b_in = 3'b000; b_mask = 3'b111; b_clrv = 0; b_clrm = 0; b_cc = 0;
    c_in = 3'b000; c_mask = 3'b101; c_clrv = 0; c_clrm = 0; c_cc = 0;
    step(3);
    chk("rst_pulse", 32'(a_pulse), 0);
    chk("rst_pend",  32'(a_pend),  0);
    chk("rst_fv",    32'(a_fv),    0);
    chk("rst_cnt",   32'(a_cnt),   0);
    rst_n = 1'b1;
    step(20);
    chk("hi_pend", 32'(a_pend), 0);
    chk("hi_cnt",  32'(a_cnt),  0);

    a_in = 3'b000; step(5);
    a_in = 3'b001; step(LAT);
    chk("r0_edge",  32'(a_edge),  32'h1);
    chk("r0_pulse", 32'(a_pulse), 1);
    step(1);
    chk("r0_edge0", 32'(a_edge),  0);
    chk("r0_pls0",  32'(a_pulse), 0);
    chk("r0_pend",  32'(a_pend),  32'h1);
    chk("r0_fv",    32'(a_fv),    1);
    chk("r0_fch",   32'(a_fch),   0);
    chk("r0_cnt",   32'(a_cnt),   1);

    a_clrv = 1; a_clrm = 3'b111; a_in = 3'b000; step(1);
    a_clrv = 0; step(LAT + 1);
    chk("clr_fv",   32'(a_fv),   0);
    chk("clr_pend", 32'(a_pend), 0);

    a_in = 3'b110; step(LAT);
    chk("m_edge2", 32'(a_edge),  32'h6);
    chk("m_pls2",  32'(a_pulse), 1);
    step(1);
    chk("m_cnt2",  32'(a_cnt),  3);
    chk("m_fch2",  32'(a_fch),  1);
    chk("m_pls2b", 32'(a_pulse), 0);
    a_in = 3'b111; step(LAT + 1);
    chk("hold_fch", 32'(a_fch),  1);
    chk("hold_pnd", 32'(a_pend), 32'h7);
    chk("hold_cnt", 32'(a_cnt),  4);

    a_clrv = 1; a_clrm = 3'b111; a_in = 3'b000; step(1);
    a_clrv = 0; step(LAT + 2);
    a_in = 3'b010; step(LAT + 2);
    chk("p1_pend", 32'(a_pend), 32'h2);
    a_in = 3'b000; step(LAT + 1);
    a_in = 3'b010; step(LAT - 1);
    a_clrv = 1; a_clrm = 3'b010; step(1);
    chk("setwin_pend", 32'(a_pend), 32'h2);
    chk("setwin_edge", 32'(a_edge), 32'h2);
    step(1);
    chk("clr2_pend", 32'(a_pend), 0);
    chk("clr2_fv1",  32'(a_fv),   1);
    a_clrv = 0; step(1);
    chk("clr2_fv0",  32'(a_fv),   0);
    chk("clr2_cnt",  32'(a_cnt),  6);

    for (int i = 0; i < 5; i++) begin
      b_in = 3'b001; step(LAT + 1);
      b_in = 3'b000; step(LAT + 1);
    end
    chk("sat_cnt", 32'(b_cnt), 3);
    b_in = 3'b001; step(LAT - 1);
    b_cc = 1; step(1);
    chk("cc_cnt",   32'(b_cnt),   1);
    chk("cc_pulse", 32'(b_pulse), 1);
    b_cc = 0; step(2);
    chk("cc_cnt2",  32'(b_cnt),   1);

    c_in = 3'b110; step(LAT);
    chk("both_r",  32'(c_edge), 32'h4);
    step(1);
    chk("both_r0", 32'(c_edge), 0);
    c_in = 3'b000; step(LAT);
    chk("both_f",  32'(c_edge), 32'h4);
    step(1);
    chk("both_cnt", 32'(c_cnt),  2);
    chk("both_pnd", 32'(c_pend), 32'h4);
    c_in = 3'b001; step(LAT);
    chk("both_c0", 32'(c_edge), 32'h1);

`ifdef OBSERVER_DEBOUNCE_EN
    a_in = 3'b100; step(3);
    a_in = 3'b000; step(LAT + 3);
    chk("glitch_cnt",  32'(a_cnt),  6);
    chk("glitch_pend", 32'(a_pend), 0);
    a_in = 3'b100; step(LAT);
    chk("stable_edge", 32'(a_edge), 32'h4);
    step(1);
`endif

    a_in = 3'b111;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_pend", 32'(a_pend), 0);
    chk("mid_cnt",  32'(a_cnt),  0);
    chk("mid_fv",   32'(a_fv),   0);
    chk("mid_cntb", 32'(b_cnt),  0);
    step(2);
    rst_n = 1'b1;
    step(LAT + 6);
    chk("rearm_cnt",  32'(a_cnt),  0);
    chk("rearm_pend", 32'(a_pend), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
